// File: rtl/fpu_pkg.sv
// Shared floating-point definitions: word width, +0.0 encoding and the
// accumulator state encoding.
package fpu_pkg;

  localparam int unsigned FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h00000000;

  typedef enum logic {
    ACC,
    HOLD
  } state_t;

endpackage

// File: rtl/fp_add.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// with subnormal support and NaN/infinity propagation.
module fp_add
  import fpu_pkg::*;
(
  input  logic [FP_W-1:0] operand_a,
  input  logic [FP_W-1:0] operand_b,
  output logic [FP_W-1:0] result
);

  logic [31:0] big, sml;
  logic [7:0]  eb, es, diff;
  logic [26:0] mb, ms, ms_al, lost_mask;
  logic [27:0] sum;
  logic [9:0]  e;
  logic        up;
  logic [24:0] m;

  always_comb begin
    big  = (operand_a[30:0] >= operand_b[30:0]) ? operand_a : operand_b;
    sml  = (operand_a[30:0] >= operand_b[30:0]) ? operand_b : operand_a;
    eb   = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    es   = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    mb   = {big[30:23] != 8'd0, big[22:0], 3'b000};
    ms   = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
    diff = eb - es;

    // Bits shifted out of the smaller operand collapse into the sticky bit.
    lost_mask = ~({27{1'b1}} << diff);
    ms_al     = ms >> diff;
    ms_al[0]  = ms_al[0] | (|(ms & lost_mask));

    if (big[31] == sml[31]) sum = {1'b0, mb} + {1'b0, ms_al};
    else                    sum = {1'b0, mb} - {1'b0, ms_al};

    e = {2'b00, eb};
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e   = e + 10'd1;
    end
    for (int unsigned i = 0; i < 26; i++) begin
      if (!sum[26] && e > 10'd1) begin
        sum = sum << 1;
        e   = e - 10'd1;
      end
    end

    up = sum[2] & (sum[3] | sum[1] | sum[0]);
    m  = {1'b0, sum[26:3]} + {24'd0, up};
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'd1;
    end

    // A result with no hidden bit stays subnormal (exponent field 0).
    result = {big[31], (m[23] ? e[7:0] : 8'd0), m[22:0]};
    if (e >= 10'd255)
      result = {big[31], 8'hff, 23'd0};
    if (sum == 28'd0)
      result = {big[31] & sml[31], 31'd0};
    if (big[30:23] == 8'hff)
      result = (big[22:0] != 23'd0 || (sml[30:0] == big[30:0] && sml[31] != big[31]))
               ? 32'h7fc00000 : big;
  end

endmodule

// File: rtl/fp_accumulate.sv
// Floating-point group accumulator: sums terms until in_last, then holds
// the sum, saturating term count and saturation flag until taken.
module fp_accumulate
  import fpu_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  state_t           state, state_next;
  logic [FP_W-1:0]  acc, sum;
  logic [CNT_W-1:0] count, count_inc;
  logic             sat, sat_inc, accept, deliver;

  fp_add u_fp_add (
    .operand_a (acc),
    .operand_b (in_data),
    .result    (sum)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    unique case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_next = HOLD;
      end
      HOLD:    if (out_ready) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;
  assign count_inc = (&count) ? count : count + CNT_W'(1);
  assign sat_inc   = sat | (&count);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc       <= FP_ZERO;
      count     <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= FP_ZERO;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      state <= state_next;
      if (deliver) begin
        out_valid <= 1'b0;
        acc       <= FP_ZERO;
        count     <= '0;
        sat       <= 1'b0;
      end else if (accept) begin
        acc   <= sum;
        count <= count_inc;
        sat   <= sat_inc;
        if (in_last) begin
          out_valid <= 1'b1;
          out_data  <= sum;
          out_count <= count_inc;
          out_sat   <= sat_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_accumulate.sv
// Directed bench for fp_accumulate: default instance plus a CNT_W=2
// instance sharing the same stimulus for the saturation case.
module tb_fp_accumulate;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, out_sat;
  logic [31:0] out_data;
  logic [7:0]  out_count;
  logic        s_in_ready, s_out_valid, s_out_sat;
  logic [31:0] s_out_data;
  logic [1:0]  s_out_count;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fp_accumulate u_dut (
    .clk, .rst, .in_valid, .in_ready, .in_data, .in_last,
    .out_valid, .out_ready, .out_data, .out_count, .out_sat
  );

  fp_accumulate #(.CNT_W(2)) u_sat (
    .clk, .rst, .in_valid, .in_ready(s_in_ready), .in_data, .in_last,
    .out_valid(s_out_valid), .out_ready, .out_data(s_out_data),
    .out_count(s_out_count), .out_sat(s_out_sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives one term and returns at the next negedge.
  task automatic send(input logic [31:0] d, input logic last);
    check("in_ready_acc", {31'd0, in_ready}, 32'd1);
    check("out_valid_acc", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b1;
    in_data  = 32'h7f7fffff;
  endtask

  task automatic check_out(input string tag, input logic [31:0] d,
                           input logic [31:0] c, input logic s);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_count"}, {24'd0, out_count}, c);
    check({tag, "_sat"}, {31'd0, out_sat}, {31'd0, s});
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'h0);
    check("rst_count", {24'd0, out_count}, 32'd0);
    check("rst_sat", {31'd0, out_sat}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1.0 + 1.0, result one cycle after the last accept
    send(32'h3f800000, 1'b0);
    send(32'h3f800000, 1'b1);
    idle();
    check_out("two_ones", 32'h40000000, 32'd2, 1'b0);
    @(negedge clk);
    check("two_ones_cleared", {31'd0, out_valid}, 32'd0);

    // 150.25 + -150.0 with idle gaps (garbage data/last ignored)
    repeat (2) @(negedge clk);
    send(32'h43164000, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    send(32'hc3160000, 1'b1);
    idle();
    check_out("cancel", 32'h3e800000, 32'd2, 1'b0);
    @(negedge clk);

    // 1.0 + -1.25 held for 5 cycles with junk on the input
    out_ready = 1'b0;
    send(32'h3f800000, 1'b0);
    send(32'hbfa00000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check_out("hold", 32'hbe800000, 32'd2, 1'b0);
      in_valid = 1'b1; in_data = 32'h40400000; in_last = 1'b1;
      @(negedge clk);
    end
    idle();
    check_out("hold_end", 32'hbe800000, 32'd2, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_cleared", {31'd0, out_valid}, 32'd0);

    // 1.0 + -1.0 then an immediate single-term group
    send(32'h3f800000, 1'b0);
    send(32'hbf800000, 1'b1);
    in_valid = 1'b1; in_data = 32'h3fa00000; in_last = 1'b1;
    check_out("zero_sum", 32'h00000000, 32'd2, 1'b0);
    @(negedge clk);
    send(32'h3fa00000, 1'b1);
    idle();
    check_out("single", 32'h3fa00000, 32'd1, 1'b0);
    @(negedge clk);

    // Five 1.0 terms: CNT_W=2 instance saturates, default does not
    for (int i = 0; i < 5; i++) send(32'h3f800000, i == 4);
    idle();
    check_out("five", 32'h40a00000, 32'd5, 1'b0);
    check("sat_valid", {31'd0, s_out_valid}, 32'd1);
    check("sat_data", s_out_data, 32'h40a00000);
    check("sat_count", {30'd0, s_out_count}, 32'd3);
    check("sat_sat", {31'd0, s_out_sat}, 32'd1);
    @(negedge clk);
    check("sat_cleared", {31'd0, s_out_valid}, 32'd0);

    // Reset after two accepted terms discards the partial sum
    send(32'h3f800000, 1'b0);
    send(32'h3f800000, 1'b0);
    idle();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    send(32'h3f800000, 1'b1);
    idle();
    check_out("after_rst", 32'h3f800000, 32'd1, 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
